pc_sequencer: RTL
=================

# pc_sequencer

Next-PC controller for the single-cycle MIPS core. It owns the program counter register and chooses the next fetch address each cycle from sequential, branch, jump, register-jump and (optionally) exception sources. It also handles stalls, a post-reset boot hold and a halt state. It sits between the control/decode logic and instruction memory, and replaces direct PCin driving of the program counter.

## Interface
- RESET_VECTOR, 32'h0000_0000, fetch address loaded on reset; bits [1:0] must be 0
- BOOT_CYCLES, 2, cycles the PC is held at RESET_VECTOR after reset; range 1..15
- EXC_VECTOR, 32'h0000_0080, exception handler address; used only with PC_SEQ_EXC_EN
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  freeze PC; all control inputs ignored this cycle
- branch_taken  in  1  take the branch target
- branch_imm  in  16  raw I-type immediate
- jump  in  1  J/JAL
- jump_index  in  26  J-type target field
- jump_reg  in  1  JR/JALR
- rs_value  in  32  register-jump target
- halt_req  in  1  enter HALT (break/syscall-halt decode)
- exc_req  in  1  exception request; present only with PC_SEQ_EXC_EN
- pc  out  32  current fetch address
- pc_plus4  out  32  pc + 4, for link writes
- fetch_valid  out  1  high in RUN when not stalled
- halted  out  1  high in HALT
- exc_pc  out  32  PC of the faulting instruction; present only with PC_SEQ_EXC_EN

## Operation
- FSM states: BOOT, RUN, HALT.
- BOOT: pc = RESET_VECTOR. A down-counter is loaded with BOOT_CYCLES-1 and transitions to RUN when it reaches 0. All control inputs are ignored.
- RUN, stall=1: pc holds and fetch_valid=0.
- RUN, stall=0, next-PC priority: exc_req > jump_reg > jump > branch_taken > pc_plus4.
- Targets:
  - pc_plus4 = pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - branch = pc_plus4 + (sign_extend(branch_imm) << 2), modulo 2^32.
  - jump = {pc_plus4[31:28], jump_index, 2'b00}.
  - jump_reg = {rs_value[31:2], 2'b00}. Low bits are forced to 0.
- halt_req with stall=0 in RUN: pc is not updated and the state moves to HALT. halt_req outranks every target except exc_req.
- HALT: pc frozen, fetch_valid=0, halted=1. Only reset leaves HALT. In HALT, exc_req is ignored.
- Reset at any cycle overrides all inputs and any state.

## Timing
- Reset values: pc=RESET_VECTOR, pc_plus4=RESET_VECTOR+4, fetch_valid=0, halted=0, state=BOOT, exc_pc=0.
- pc updates on the rising edge following the cycle its control input is sampled, giving 1-cycle latency. pc_plus4 is combinational from pc.
- fetch_valid is combinational: (state==RUN) & ~stall.
- First RUN cycle is the BOOT_CYCLES-th cycle after reset deassertion. During that cycle pc=RESET_VECTOR and fetch_valid=1.
- Simultaneous inputs:
  - stall+branch: stall wins; decode must re-present the branch.
  - stall+exc_req: the exception is taken (see Configuration).
  - jump+jump_reg: jump_reg wins.

## Configuration
- PC_SEQ_EXC_EN defined:
  - exc_req and exc_pc exist.
  - exc_req in RUN, even while stalled, loads pc=EXC_VECTOR and exc_pc=current pc on the next edge.
  - jump_reg with rs_value[1:0]!=0 is treated as an exception with exc_pc=current pc.
- PC_SEQ_EXC_EN undefined:
  - Neither port exists.
  - Misaligned jump_reg targets are silently aligned.

## Structure
- Shared package pc_seq_pkg contains:
  - state enum {BOOT, RUN, HALT}
  - a next-PC select enum {SEL_HOLD, SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_EXC}
  - width constants PC_W=32, IMM_W=16, JIDX_W=26
- One sub-module, pc_target_calc, is combinational. It computes pc_plus4, the branch target and the jump target from pc and the instruction fields. The FSM, priority select and PC register stay in pc_sequencer.

## Test plan
- Reset high 2 cycles, then low, BOOT_CYCLES=2 -> pc=0 and fetch_valid=0 for 1 cycle, then fetch_valid=1 at pc=0, then pc=4, 8, 12 on successive edges.
- At pc=0x100, branch_taken=1, branch_imm=16'hFFFE -> pc=0x0FC next edge. At pc=0x100, branch_imm=16'h0003 -> pc=0x110.
- At pc=0x0040_0000, jump=1, jump_index=26'h0000_010 and simultaneously branch_taken=1 -> pc=0x0000_0040. Also, jump_reg=1 with jump=1 and rs_value=0x1234_5677 -> pc=0x1234_5674 (no EXC_EN).
- At pc=0x20, stall high 3 cycles with branch_taken asserted -> pc stays 0x20 and fetch_valid=0. After release with inputs idle -> pc=0x24.
- At pc=0x30, halt_req=1 -> halted=1 and pc stays 0x30 for 10 cycles despite jump=1. Then reset=1 -> next edge pc=RESET_VECTOR, halted=0.
- With PC_SEQ_EXC_EN, at pc=0x200 with stall=1, exc_req=1 -> pc=0x80, exc_pc=0x200. Also, jump_reg with rs_value=0x302 -> pc=0x80, exc_pc=current pc. Then pc=0xFFFF_FFFC with inputs idle -> pc wraps to 0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and widths for the next-PC sequencer.
// Holds the FSM state encoding, the next-PC source select encoding,
// the datapath widths and a small word-alignment helper.
package pc_seq_pkg;

  localparam int PC_W   = 32;
  localparam int IMM_W  = 16;
  localparam int JIDX_W = 26;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_SEQ  = 3'd1,
    SEL_BR   = 3'd2,
    SEL_J    = 3'd3,
    SEL_JR   = 3'd4,
    SEL_EXC  = 3'd5
  } pc_sel_t;

  // Clear the two byte-offset bits so the result is a word address.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: purely combinational target generation.
// From the current pc and the raw instruction fields it produces the
// sequential address, the PC-relative branch target and the J-type
// region jump target. All arithmetic wraps modulo 2^32.
module pc_target_calc
  import pc_seq_pkg::*;
(
  input  logic [PC_W-1:0]   pc,
  input  logic [IMM_W-1:0]  branch_imm,
  input  logic [JIDX_W-1:0] jump_index,
  output logic [PC_W-1:0]   pc_plus4,
  output logic [PC_W-1:0]   br_target,
  output logic [PC_W-1:0]   j_target
);

  logic signed [PC_W-1:0] br_offset;

  // Sequential, branch and jump targets; the branch offset is the
  // sign-extended immediate scaled to a byte offset.
  always_comb begin
    pc_plus4  = pc + 32'd4;
    br_offset = {{(PC_W-IMM_W-2){branch_imm[IMM_W-1]}}, branch_imm, 2'b00};
    br_target = pc_plus4 + br_offset;
    j_target  = {pc_plus4[PC_W-1:PC_W-4], jump_index, 2'b00};
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the single-cycle MIPS core.
// Owns the program counter and a BOOT/RUN/HALT FSM. In RUN the next
// fetch address is chosen with priority
//   exc_req > stall > halt_req > jump_reg > jump > branch_taken > pc+4.
// Optional feature macro: PC_SEQ_EXC_EN adds the exc_req input, the
// exc_pc output, and traps misaligned register-jump targets. Without it
// misaligned register-jump targets are silently word aligned.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BOOT_CYCLES  = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] rs_value,
  input  logic        halt_req,
`ifdef PC_SEQ_EXC_EN
  input  logic        exc_req,
  output logic [31:0] exc_pc,
`endif
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted
);

  localparam logic [3:0] BOOT_LOAD = 4'(BOOT_CYCLES - 1);

  pc_state_t       state, state_next;
  pc_sel_t         sel;
  logic [3:0]      boot_cnt;
  logic            boot_done;
  logic            exc_take;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] j_target;
  logic [PC_W-1:0] jr_target;
  logic [PC_W-1:0] pc_next;

  pc_target_calc u_target (
    .pc         (pc),
    .branch_imm (branch_imm),
    .jump_index (jump_index),
    .pc_plus4   (pc_plus4),
    .br_target  (br_target),
    .j_target   (j_target)
  );

  assign jr_target = word_align(rs_value);

  // BOOT ends on the edge where the down-counter reaches zero, so the
  // first RUN cycle is the BOOT_CYCLES-th cycle after reset deasserts.
  assign boot_done = (boot_cnt <= 4'd1);

  // Exception request: external request, or a misaligned register jump.
  // Both only count in RUN; BOOT and HALT ignore them.
`ifdef PC_SEQ_EXC_EN
  assign exc_take = (state == RUN) &
                    (exc_req | (~stall & ~halt_req & jump_reg & (|rs_value[1:0])));
`else
  assign exc_take = 1'b0;
`endif

  // State register and boot hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      boot_cnt <= BOOT_LOAD;
    end else begin
      state <= state_next;
      if (state == BOOT && boot_cnt != 4'd0) boot_cnt <= boot_cnt - 4'd1;
    end
  end

  // Next-state and next-PC source selection.
  always_comb begin
    state_next = state;
    sel        = SEL_HOLD;
    unique case (state)
      BOOT: begin
        if (boot_done) state_next = RUN;
      end
      RUN: begin
        if (exc_take)          sel = SEL_EXC;
        else if (stall)        sel = SEL_HOLD;
        else if (halt_req) begin
          sel        = SEL_HOLD;
          state_next = HALT;
        end
        else if (jump_reg)     sel = SEL_JR;
        else if (jump)         sel = SEL_J;
        else if (branch_taken) sel = SEL_BR;
        else                   sel = SEL_SEQ;
      end
      HALT: begin
        sel = SEL_HOLD;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // Next-PC multiplexer.
  always_comb begin
    pc_next = pc;
    unique case (sel)
      SEL_SEQ:  pc_next = pc_plus4;
      SEL_BR:   pc_next = br_target;
      SEL_J:    pc_next = j_target;
      SEL_JR:   pc_next = jr_target;
      SEL_EXC:  pc_next = EXC_VECTOR;
      default:  pc_next = pc;
    endcase
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_VECTOR;
    else       pc <= pc_next;
  end

`ifdef PC_SEQ_EXC_EN
  // Faulting-instruction PC capture.
  always_ff @(posedge clk) begin
    if (reset)                exc_pc <= 32'h0000_0000;
    else if (sel == SEL_EXC)  exc_pc <= pc;
  end
`endif

  assign fetch_valid = (state == RUN) & ~stall;
  assign halted      = (state == HALT);

endmodule
